// File: rtl/time_pkg.sv
// Shared constants and digit-limit helper for the time-setting datapath.
package time_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned MAX_EVEN      = 9;
    localparam int unsigned MAX_ODD       = 5;
    localparam int unsigned MAX_H10       = 2;
    localparam int unsigned MAX_H01_AT_20 = 3;
    localparam int unsigned H10_IDX       = 5;
    localparam int unsigned H01_IDX       = 4;

    // Largest legal value of digit 'index'; h10 is the (already legal) hour-tens digit.
    function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned        index,
                                                     input logic [DIGIT_W-1:0] h10,
                                                     input logic               hour_en);
        logic [DIGIT_W-1:0] m;
        if (hour_en && index == H10_IDX) begin
            m = DIGIT_W'(MAX_H10);
        end else if (hour_en && index == H01_IDX) begin
            m = (h10 >= DIGIT_W'(MAX_H10)) ? DIGIT_W'(MAX_H01_AT_20) : DIGIT_W'(MAX_EVEN);
        end else if (index[0]) begin
            m = DIGIT_W'(MAX_ODD);
        end else begin
            m = DIGIT_W'(MAX_EVEN);
        end
        return m;
    endfunction

endpackage

// File: rtl/time_set_multi_btn_repeat.sv
// Rising-edge step with hold-to-repeat for one debounced button level.
// REPEAT_PERIOD must not exceed HOLD_DELAY (the counter reloads below HOLD_DELAY).
module btn_repeat #(
    parameter int unsigned HOLD_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic MCLK,
    input  logic RESET_N,
    input  logic lvl,
    input  logic clr,
    output logic step_c
);

    localparam int unsigned CNT_W  = $clog2(HOLD_DELAY + 1);
    localparam int unsigned RELOAD = HOLD_DELAY - REPEAT_PERIOD + 1;

    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_c;

    assign rise_c = lvl & ~lvl_q;

    // Counter holds cycles since the edge; zero means idle until the next edge.
    always_comb begin
        lvl_d  = lvl;
        cnt_d  = cnt_q;
        step_c = 1'b0;
        if (clr || !lvl) begin
            cnt_d = '0;
        end else if (rise_c) begin
            step_c = 1'b1;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != '0) begin
            if (cnt_q == CNT_W'(HOLD_DELAY)) begin
                step_c = 1'b1;
                cnt_d  = CNT_W'(RELOAD);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_multi.sv
// Digit-field time setter: edits a working copy with a cursor, publishes on commit.
module time_set_multi
    import time_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned HOUR_EN       = 1,
    parameter int unsigned HOLD_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned BLINK_HALF    = 25_000_000
) (
    input  logic                            MCLK,
    input  logic                            RESET_N,
    input  logic                            enable,
    input  logic                            inc,
    input  logic                            dec,
    input  logic                            left,
    input  logic                            right,
    input  logic                            commit,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   cur_digits,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   work_digits,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   upd_digits,
    output logic                            upd_valid,
    output logic [$clog2(NUM_DIGITS)-1:0]   location,
    output logic                            blink
);

    localparam int unsigned W          = DIGIT_W * NUM_DIGITS;
    localparam int unsigned LOC_W      = $clog2(NUM_DIGITS);
    localparam int unsigned BLINK_W    = $clog2(BLINK_HALF + 1);
    localparam logic        HOUR_FIELD = (HOUR_EN != 0) && (NUM_DIGITS == 6);
    localparam logic [LOC_W-1:0] LOC_TOP = LOC_W'(NUM_DIGITS - 1);

    logic               en_q, en_d, left_q, left_d, right_q, right_d, commit_q, commit_d;
    logic [W-1:0]       work_q, work_d, upd_q, upd_d;
    logic               upd_valid_q, upd_valid_d, blink_q, blink_d;
    logic [LOC_W-1:0]   loc_q, loc_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    logic               entry_c, rpt_clr_c, inc_step_c, dec_step_c;
    logic               left_rise_c, right_rise_c, commit_rise_c;
    int unsigned        loc_idx;
    logic [DIGIT_W-1:0] step_dig, step_max;

    assign entry_c       = enable & ~en_q;
    assign rpt_clr_c     = ~(enable & en_q) | (inc & dec);
    assign left_rise_c   = left & ~left_q;
    assign right_rise_c  = right & ~right_q;
    assign commit_rise_c = commit & ~commit_q;
    assign loc_idx       = 32'(loc_q);

    btn_repeat #(.HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc_rpt (
        .MCLK(MCLK), .RESET_N(RESET_N), .lvl(inc), .clr(rpt_clr_c), .step_c(inc_step_c)
    );

    btn_repeat #(.HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec_rpt (
        .MCLK(MCLK), .RESET_N(RESET_N), .lvl(dec), .clr(rpt_clr_c), .step_c(dec_step_c)
    );

    // Clamp each loaded digit to its limit, hour-tens first so hour-ones sees the legal value.
    function automatic logic [W-1:0] clamp_load(input logic [W-1:0] raw);
        logic [W-1:0]       res;
        logic [DIGIT_W-1:0] d, m, h10;
        res = raw;
        h10 = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            d = raw[i*DIGIT_W +: DIGIT_W];
            m = digit_max(unsigned'(i), h10, HOUR_FIELD);
            if (d > m) d = m;
            if (i == int'(NUM_DIGITS) - 1) h10 = d;
            res[i*DIGIT_W +: DIGIT_W] = d;
        end
        return res;
    endfunction

    // Next-state: entry load, cursor, step, commit capture and blink phase.
    always_comb begin
        work_d      = work_q;
        upd_d       = upd_q;
        upd_valid_d = 1'b0;
        loc_d       = loc_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        en_d        = enable;
        left_d      = left;
        right_d     = right;
        commit_d    = commit;
        step_dig    = work_q[loc_idx*DIGIT_W +: DIGIT_W];
        step_max    = digit_max(loc_idx, work_q[W-1 -: DIGIT_W], HOUR_FIELD);

        if (!enable) begin
            loc_d       = LOC_TOP;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (entry_c) begin
            work_d      = clamp_load(cur_digits);
            loc_d       = LOC_TOP;
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else begin
            if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end

            if (commit_rise_c) begin
                upd_d       = work_q;
                upd_valid_d = 1'b1;
            end

            if (left_rise_c && !right_rise_c && loc_q != LOC_TOP) begin
                loc_d       = loc_q + LOC_W'(1);
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end else if (right_rise_c && !left_rise_c && loc_q != '0) begin
                loc_d       = loc_q - LOC_W'(1);
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end

            if (inc_step_c || dec_step_c) begin
                if (inc_step_c) begin
                    step_dig = (step_dig >= step_max) ? '0 : step_dig + DIGIT_W'(1);
                end else begin
                    step_dig = (step_dig == '0) ? step_max : step_dig - DIGIT_W'(1);
                end
                work_d[loc_idx*DIGIT_W +: DIGIT_W] = step_dig;
                if (HOUR_FIELD && work_d[W-1 -: DIGIT_W] == DIGIT_W'(MAX_H10) &&
                    work_d[W-1-DIGIT_W -: DIGIT_W] > DIGIT_W'(MAX_H01_AT_20)) begin
                    work_d[W-1-DIGIT_W -: DIGIT_W] = DIGIT_W'(MAX_H01_AT_20);
                end
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            en_q        <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            commit_q    <= 1'b0;
            work_q      <= '0;
            upd_q       <= '0;
            upd_valid_q <= 1'b0;
            loc_q       <= LOC_TOP;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            en_q        <= en_d;
            left_q      <= left_d;
            right_q     <= right_d;
            commit_q    <= commit_d;
            work_q      <= work_d;
            upd_q       <= upd_d;
            upd_valid_q <= upd_valid_d;
            loc_q       <= loc_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign work_digits = work_q;
    assign upd_digits  = upd_q;
    assign upd_valid   = upd_valid_q;
    assign location    = loc_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_time_set_multi.sv
// Bench for time_set_multi: directed scenarios plus random stimulus against a digit-array model.
module tb_time_set_multi;

    localparam int ND = 6;
    localparam int HD = 20;
    localparam int RP = 5;
    localparam int BH = 8;
    localparam int P_INC = 0, P_DEC = 1, P_LEFT = 2, P_RIGHT = 3, P_COMMIT = 4;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        enable = 1'b0, inc = 1'b0, dec = 1'b0, left = 1'b0, right = 1'b0, commit = 1'b0;
    logic [23:0] cur_digits = '0;
    logic [23:0] work_digits, upd_digits;
    logic        upd_valid, blink;
    logic [2:0]  location;

    always #5 MCLK = ~MCLK;

    time_set_multi #(
        .NUM_DIGITS(ND), .HOUR_EN(1), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .BLINK_HALF(BH)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .enable(enable), .inc(inc), .dec(dec),
        .left(left), .right(right), .commit(commit), .cur_digits(cur_digits),
        .work_digits(work_digits), .upd_digits(upd_digits), .upd_valid(upd_valid),
        .location(location), .blink(blink)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: one integer per digit, cursor index, hold ages (-1 = idle).
    int m_work[ND];
    int m_upd[ND];
    int m_valid, m_loc, m_blink, m_bcnt, inc_age, dec_age;
    bit p_en, p_inc, p_dec, p_l, p_r, p_c;

    function automatic int lim(input int i, input int h10);
        if (i == 5) return 2;
        if (i == 4) return (h10 == 2) ? 3 : 9;
        return (i % 2 == 1) ? 5 : 9;
    endfunction

    function automatic logic [23:0] pack(input int a[ND]);
        logic [23:0] r;
        for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'(a[i]);
        return r;
    endfunction

    task automatic hold_update(input bit lvl, input bit rise, input bit blocked,
                               inout int age, output bit step);
        step = 1'b0;
        if (blocked || !lvl) begin
            age = -1;
        end else if (rise) begin
            age  = 0;
            step = 1'b1;
        end else if (age >= 0) begin
            age++;
            step = (age >= HD) && ((age - HD) % RP == 0);
        end
    endtask

    task automatic model_clock();
        bit entry, active, ie, de, le, re, ce, is, ds;
        int old[ND];
        int ol, d, m;
        if (!RESET_N) begin
            for (int i = 0; i < ND; i++) begin m_work[i] = 0; m_upd[i] = 0; end
            m_valid = 0; m_loc = ND - 1; m_blink = 0; m_bcnt = 0;
            inc_age = -1; dec_age = -1;
            p_en = 0; p_inc = 0; p_dec = 0; p_l = 0; p_r = 0; p_c = 0;
        end else begin
            entry  = enable && !p_en;
            active = enable && p_en;
            ie = inc && !p_inc; de = dec && !p_dec;
            le = left && !p_l;  re = right && !p_r; ce = commit && !p_c;
            hold_update(inc, ie, !active || (inc && dec), inc_age, is);
            hold_update(dec, de, !active || (inc && dec), dec_age, ds);
            old = m_work;
            ol  = m_loc;
            m_valid = 0;
            if (!enable) begin
                m_loc = ND - 1; m_blink = 0; m_bcnt = 0;
            end else if (entry) begin
                for (int i = ND - 1; i >= 0; i--) begin
                    d = int'(cur_digits[i*4 +: 4]);
                    m = lim(i, m_work[5]);
                    m_work[i] = (d > m) ? m : d;
                end
                m_loc = ND - 1; m_blink = 1; m_bcnt = 0;
            end else begin
                m_bcnt++;
                if (m_bcnt == BH) begin m_blink = 1 - m_blink; m_bcnt = 0; end
                if (ce) begin m_upd = old; m_valid = 1; end
                if (le && !re && ol < ND - 1) begin m_loc = ol + 1; m_blink = 1; m_bcnt = 0; end
                if (re && !le && ol > 0)      begin m_loc = ol - 1; m_blink = 1; m_bcnt = 0; end
                if (is || ds) begin
                    m = lim(ol, old[5]);
                    d = old[ol];
                    if (is) d = (d >= m) ? 0 : d + 1;
                    else    d = (d == 0) ? m : d - 1;
                    m_work[ol] = d;
                    if (m_work[5] == 2 && m_work[4] > 3) m_work[4] = 3;
                    m_blink = 1; m_bcnt = 0;
                end
            end
            p_en = enable; p_inc = inc; p_dec = dec; p_l = left; p_r = right; p_c = commit;
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        model_clock();
        #1;
        check("work",  32'(work_digits), 32'(pack(m_work)));
        check("upd",   32'(upd_digits),  32'(pack(m_upd)));
        check("valid", 32'(upd_valid),   32'(m_valid));
        check("loc",   32'(location),    32'(m_loc));
        check("blink", 32'(blink),       32'(m_blink));
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            P_INC:    inc    = v;
            P_DEC:    dec    = v;
            P_LEFT:   left   = v;
            P_RIGHT:  right  = v;
            default:  commit = v;
        endcase
    endtask

    task automatic pulse(input int which);
        set_btn(which, 1'b1);
        tick();
        set_btn(which, 1'b0);
        tick();
    endtask

    int          exp_pos[5] = '{0, 20, 25, 30, 35};
    int          pos[$];
    logic [23:0] prev_work;

    initial begin
        // Reset state
        RESET_N = 1'b0;
        tick();
        tick();
        check("rst_work",  32'(work_digits), 32'h0);
        check("rst_upd",   32'(upd_digits),  32'h0);
        check("rst_valid", 32'(upd_valid),   32'h0);
        check("rst_loc",   32'(location),    32'd5);
        check("rst_blink", 32'(blink),       32'h0);

        // Entry load and commit pulse
        RESET_N = 1'b1;
        cur_digits = 24'h123456;
        enable = 1'b1;
        tick();
        check("entry_work", 32'(work_digits), 32'h123456);
        check("entry_loc",  32'(location),    32'd5);
        commit = 1'b1;
        tick();
        check("commit_valid", 32'(upd_valid),  32'h1);
        check("commit_upd",   32'(upd_digits), 32'h123456);
        commit = 1'b0;
        tick();
        check("commit_pulse", 32'(upd_valid), 32'h0);

        // Seconds digits wrap without carry
        repeat (5) pulse(P_RIGHT);
        check("cursor_zero", 32'(location), 32'd0);
        repeat (3) pulse(P_INC);
        check("sec01_to9", 32'(work_digits), 32'h123459);
        pulse(P_INC);
        check("sec01_wrap", 32'(work_digits), 32'h123450);
        pulse(P_DEC);
        check("sec01_dec_wrap", 32'(work_digits), 32'h123459);
        pulse(P_LEFT);
        pulse(P_INC);
        check("sec10_wrap", 32'(work_digits), 32'h123409);

        // Hour field clamp
        enable = 1'b0;
        tick();
        cur_digits = 24'h190000;
        enable = 1'b1;
        tick();
        check("hour_load", 32'(work_digits), 32'h190000);
        pulse(P_INC);
        check("hour_clamp", 32'(work_digits), 32'h230000);
        pulse(P_RIGHT);
        pulse(P_INC);
        check("h01_wrap3", 32'(work_digits), 32'h200000);

        // Auto-repeat timing
        repeat (4) pulse(P_RIGHT);
        inc = 1'b1;
        for (int k = 0; k < 40; k++) begin
            prev_work = work_digits;
            tick();
            if (work_digits != prev_work) pos.push_back(k);
        end
        inc = 1'b0;
        tick();
        check("hold_count", 32'(pos.size()), 32'd5);
        for (int i = 0; i < pos.size() && i < 5; i++)
            check($sformatf("hold_step%0d", i), 32'(pos[i]), 32'(exp_pos[i]));
        check("hold_value", 32'(work_digits), 32'h200005);
        inc = 1'b1;
        dec = 1'b1;
        repeat (40) tick();
        inc = 1'b0;
        dec = 1'b0;
        tick();
        check("incdec_nostep", 32'(work_digits), 32'h200005);

        // Exit discards; cursor saturation; simultaneous left/right
        enable = 1'b0;
        tick();
        cur_digits = 24'h000000;
        enable = 1'b1;
        tick();
        repeat (5) pulse(P_RIGHT);
        pulse(P_INC);
        check("edit_001", 32'(work_digits), 32'h000001);
        enable = 1'b0;
        tick();
        check("exit_valid", 32'(upd_valid),   32'h0);
        check("exit_upd",   32'(upd_digits),  32'h123456);
        check("exit_work",  32'(work_digits), 32'h000001);
        check("exit_loc",   32'(location),    32'd5);
        enable = 1'b1;
        tick();
        pulse(P_LEFT);
        check("left_sat", 32'(location), 32'd5);
        pulse(P_RIGHT);
        left = 1'b1;
        right = 1'b1;
        tick();
        left = 1'b0;
        right = 1'b0;
        tick();
        check("lr_nomove", 32'(location), 32'd4);

        // Reset mid-edit with a commit edge
        pulse(P_INC);
        check("pre_rst_work", 32'(work_digits), 32'h010000);
        RESET_N = 1'b0;
        commit = 1'b1;
        tick();
        check("midrst_work",  32'(work_digits), 32'h0);
        check("midrst_upd",   32'(upd_digits),  32'h0);
        check("midrst_valid", 32'(upd_valid),   32'h0);
        check("midrst_loc",   32'(location),    32'd5);
        RESET_N = 1'b1;
        commit = 1'b0;
        tick();
        check("postrst_valid", 32'(upd_valid), 32'h0);

        // Random traffic against the model
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            RESET_N = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 24) == 0) inc = ~inc;
            if ($urandom_range(0, 39) == 0) dec = ~dec;
            if ($urandom_range(0, 3) == 0)  left = ~left;
            if ($urandom_range(0, 3) == 0)  right = ~right;
            if ($urandom_range(0, 14) == 0) commit = ~commit;
            if ($urandom_range(0, 49) == 0) cur_digits = 24'($urandom());
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
